matmul_host_sequencer: RTL and testbench

//  Host-side initiator for the RAM-backed matrix_multiplication block.
//  - Accepts A rows then B rows on a valid/ready input stream and writes them into the A/B BRAMs.
//  - Pulses the multiply, waits for done_mat_mul, then reads C rows back out on an output stream.
//  - Sits between the test/host fabric and the matmul data_pi/addr_pi/we_*/start ports.

---
 rtl/matmul_host_sequencer.sv | 269 ++++++++++++++++++++++++++
 tb/tb_matmul_host_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_host_sequencer.sv
// Host-side initiator for the RAM-backed matrix multiplier.
// Streams A rows then B rows into the operand BRAMs, pulses the multiply,
// waits for completion (with a bounded timeout) and streams the C rows back out.
module matmul_host_sequencer #(
    parameter int DWIDTH       = 8,
    parameter int MAT_MUL_SIZE = 4,
    parameter int AWIDTH       = 7,
    parameter int WR_LAT       = 2,
    parameter int RD_LAT       = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cmd_start,
    output logic                           busy,
    output logic                           cmd_done,
    output logic                           timeout_err,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [MAT_MUL_SIZE*DWIDTH-1:0] in_data,
    output logic                           out_valid,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data,
    output logic                           enable_writing_to_mem,
    output logic                           enable_reading_from_mem,
    output logic [AWIDTH-1:0]              addr_pi,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0] data_pi,
    output logic                           we_a,
    output logic                           we_b,
    output logic                           we_c,
    output logic                           start_mat_mul,
    input  logic                           done_mat_mul,
    input  logic [MAT_MUL_SIZE*DWIDTH-1:0] data_from_out_mat
);

    localparam int WW  = MAT_MUL_SIZE * DWIDTH;
    localparam int RW  = (MAT_MUL_SIZE > 1) ? $clog2(MAT_MUL_SIZE) : 1;
    localparam int RC  = RW + 1;
    localparam int DCW = $clog2(WR_LAT + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_DRAIN  = 3'd3,
        S_RUN    = 3'd4,
        S_READ   = 3'd5,
        S_FIN    = 3'd6
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [RW-1:0]            r_row;
    logic [DCW-1:0]           r_drain_cnt;
    logic [7:0]               r_to_cnt;
    logic                     r_timeout_err;
    logic [RC-1:0]            r_rd_cnt;
    logic [WR_LAT-1:0]        r_wp_vld;
    logic [WR_LAT-1:0]        r_wp_sel;
    logic [WR_LAT-1:0][WW-1:0] r_wp_data;
    logic [RD_LAT-1:0]        r_rv;

    logic                     w_in_load;
    logic                     w_hs;
    logic                     w_last_row;
    logic                     w_rd_issue;
    logic                     w_rv_younger;
    logic                     w_to_hit;

    // Shared decode of the current state and counters.
    always_comb begin
        w_in_load    = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
        w_hs         = w_in_load && in_valid;
        w_last_row   = (r_row == RW'(MAT_MUL_SIZE - 1));
        w_rd_issue   = (r_state == S_READ) && (r_rd_cnt < RC'(MAT_MUL_SIZE));
        w_to_hit     = (r_to_cnt == 8'(TIMEOUT - 1));
        w_rv_younger = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            w_rv_younger = w_rv_younger | r_rv[i];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        w_next_state            = r_state;
        busy                    = 1'b0;
        cmd_done                = 1'b0;
        in_ready                = 1'b0;
        enable_writing_to_mem   = 1'b0;
        enable_reading_from_mem = 1'b0;
        start_mat_mul           = 1'b0;
        we_c                    = 1'b0;
        addr_pi                 = {AWIDTH{1'b0}};
        case (r_state)
            S_IDLE: begin
                if (cmd_start) begin
                    w_next_state = S_LOAD_A;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_LOAD_A, S_LOAD_B: begin
                busy                  = 1'b1;
                in_ready              = 1'b1;
                enable_writing_to_mem = 1'b1;
                addr_pi               = {{(AWIDTH - RW){1'b0}}, r_row};
                if (w_hs && w_last_row) begin
                    w_next_state = (r_state == S_LOAD_A) ? S_LOAD_B : S_DRAIN;
                end else begin
                    w_next_state = r_state;
                end
            end
            S_DRAIN: begin
                busy                  = 1'b1;
                enable_writing_to_mem = 1'b1;
                if (r_drain_cnt == DCW'(WR_LAT)) begin
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_DRAIN;
                end
            end
            S_RUN: begin
                busy          = 1'b1;
                start_mat_mul = 1'b1;
                we_c          = 1'b1;
                if (done_mat_mul) begin
                    w_next_state = S_READ;
                end else if (w_to_hit) begin
                    w_next_state = S_FIN;
                end else begin
                    w_next_state = S_RUN;
                end
            end
            S_READ: begin
                busy                    = 1'b1;
                enable_reading_from_mem = 1'b1;
                if (w_rd_issue) begin
                    addr_pi = {{(AWIDTH - RW){1'b0}}, r_rd_cnt[RW-1:0]};
                end else begin
                    addr_pi = {AWIDTH{1'b0}};
                end
                if (!w_rd_issue && r_rv[RD_LAT-1] && !w_rv_younger) begin
                    w_next_state = S_FIN;
                end else begin
                    w_next_state = S_READ;
                end
            end
            S_FIN: begin
                busy         = 1'b1;
                cmd_done     = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Row counter: addresses the operand rows while loading; no gaps on stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row <= {RW{1'b0}};
        end else if ((r_state == S_IDLE) && cmd_start) begin
            r_row <= {RW{1'b0}};
        end else if (w_hs) begin
            r_row <= w_last_row ? {RW{1'b0}} : (r_row + RW'(1));
        end else begin
            r_row <= r_row;
        end
    end

    // Drain counter: keeps the write enable up until the last B write lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drain_cnt <= {DCW{1'b0}};
        end else if (r_state == S_DRAIN) begin
            r_drain_cnt <= r_drain_cnt + DCW'(1);
        end else begin
            r_drain_cnt <= {DCW{1'b0}};
        end
    end

    // Saturating RUN-cycle counter for the completion timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to_cnt <= 8'd0;
        end else if (r_state != S_RUN) begin
            r_to_cnt <= 8'd0;
        end else if (r_to_cnt != 8'hFF) begin
            r_to_cnt <= r_to_cnt + 8'd1;
        end else begin
            r_to_cnt <= r_to_cnt;
        end
    end

    // Sticky timeout flag, cleared when a new sequence is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timeout_err <= 1'b0;
        end else if ((r_state == S_IDLE) && cmd_start) begin
            r_timeout_err <= 1'b0;
        end else if ((r_state == S_RUN) && !done_mat_mul && w_to_hit) begin
            r_timeout_err <= 1'b1;
        end else begin
            r_timeout_err <= r_timeout_err;
        end
    end

    assign timeout_err = r_timeout_err;

    // Write delay pipe: aligns data and bank select with the RAM's delayed address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp_vld  <= {WR_LAT{1'b0}};
            r_wp_sel  <= {WR_LAT{1'b0}};
            r_wp_data <= '0;
        end else begin
            r_wp_vld[0]  <= w_hs;
            r_wp_sel[0]  <= w_hs && (r_state == S_LOAD_B);
            r_wp_data[0] <= w_hs ? in_data : {WW{1'b0}};
            for (int i = 1; i < WR_LAT; i++) begin
                r_wp_vld[i]  <= r_wp_vld[i-1];
                r_wp_sel[i]  <= r_wp_sel[i-1];
                r_wp_data[i] <= r_wp_data[i-1];
            end
        end
    end

    assign we_a    = r_wp_vld[WR_LAT-1] && !r_wp_sel[WR_LAT-1];
    assign we_b    = r_wp_vld[WR_LAT-1] &&  r_wp_sel[WR_LAT-1];
    assign data_pi = r_wp_data[WR_LAT-1];

    // Read address counter: issues C rows 0..N-1 on consecutive cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_cnt <= {RC{1'b0}};
        end else if (r_state != S_READ) begin
            r_rd_cnt <= {RC{1'b0}};
        end else if (w_rd_issue) begin
            r_rd_cnt <= r_rd_cnt + RC'(1);
        end else begin
            r_rd_cnt <= r_rd_cnt;
        end
    end

    // Read valid pipe: marks the cycle each issued row arrives from the RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rv <= {RD_LAT{1'b0}};
        end else begin
            r_rv[0] <= w_rd_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                r_rv[i] <= r_rv[i-1];
            end
        end
    end

    assign out_valid = r_rv[RD_LAT-1];
    assign out_data  = r_rv[RD_LAT-1] ? data_from_out_mat : {WW{1'b0}};

endmodule

// File: tb/tb_matmul_host_sequencer.sv
// Scoreboard bench for matmul_host_sequencer with a small behavioural
// model of the RAM-backed multiplier on the far side.
module tb_matmul_host_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_start;
    logic        busy, cmd_done, timeout_err;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic        enable_writing_to_mem, enable_reading_from_mem;
    logic [6:0]  addr_pi;
    logic [31:0] data_pi;
    logic        we_a, we_b, we_c, start_mat_mul;
    logic        done_mat_mul;
    logic [31:0] data_from_out_mat;

    // environment / model state
    logic        rnd_phase, rnd_done, mm_en, mm_done;
    logic [31:0] rnd_data;
    logic [6:0]  a_d1, a_d2, r1, r2, r3, r4;
    logic [3:0]  mm_cnt;
    logic [31:0] mem_a [4];
    logic [31:0] mem_b [4];
    logic [31:0] mem_c [4];

    typedef struct {
        bit          sel;
        logic [6:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_out[$];
    int total = 0, bad = 0;
    int cyc = 0, hs_idx = 0, done_cnt = 0, out_cnt = 0, out_idx = 0, last_out = 0;
    int run_cycles = 0, excl_viol = 0;

    wire [81:0] all_out = {busy, cmd_done, timeout_err, in_ready, out_valid, out_data,
                           enable_writing_to_mem, enable_reading_from_mem, addr_pi,
                           data_pi, we_a, we_b, we_c, start_mat_mul};

    assign done_mat_mul      = rnd_phase ? rnd_done : mm_done;
    assign data_from_out_mat = rnd_phase ? rnd_data : mem_c[r4[1:0]];

    matmul_host_sequencer dut (
        .clk(clk), .reset(reset), .cmd_start(cmd_start), .busy(busy),
        .cmd_done(cmd_done), .timeout_err(timeout_err), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
        .out_data(out_data), .enable_writing_to_mem(enable_writing_to_mem),
        .enable_reading_from_mem(enable_reading_from_mem), .addr_pi(addr_pi),
        .data_pi(data_pi), .we_a(we_a), .we_b(we_b), .we_c(we_c),
        .start_mat_mul(start_mat_mul), .done_mat_mul(done_mat_mul),
        .data_from_out_mat(data_from_out_mat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: event did not occur as required (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [31:0] crow(input int i);
        logic [31:0] r;
        logic [7:0]  acc;
        r = 32'd0;
        for (int j = 0; j < 4; j++) begin
            acc = 8'd0;
            for (int k = 0; k < 4; k++) begin
                acc = acc + 8'(mem_a[i][k*8 +: 8] * mem_b[k][j*8 +: 8]);
            end
            r[j*8 +: 8] = acc;
        end
        return r;
    endfunction

    // Behavioural multiplier: delayed write/read addresses, done after 10 RUN cycles.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_d1 <= 7'd0; a_d2 <= 7'd0;
            r1 <= 7'd0; r2 <= 7'd0; r3 <= 7'd0; r4 <= 7'd0;
            mm_cnt <= 4'd0; mm_done <= 1'b0;
        end else begin
            a_d1 <= addr_pi; a_d2 <= a_d1;
            r1 <= addr_pi; r2 <= r1; r3 <= r2; r4 <= r3;
            if (we_a) mem_a[a_d2[1:0]] <= data_pi;
            if (we_b) mem_b[a_d2[1:0]] <= data_pi;
            if (start_mat_mul && mm_en && !mm_done) begin
                mm_cnt <= mm_cnt + 4'd1;
                if (mm_cnt == 4'd9) begin
                    mm_done <= 1'b1;
                    for (int i = 0; i < 4; i++) mem_c[i] <= crow(i);
                end
            end else begin
                mm_cnt  <= 4'd0;
                mm_done <= 1'b0;
            end
        end
    end

    // Monitor: records accepted rows, checks writes, C rows and exclusivity.
    always @(negedge clk) begin
        wr_t e;
        if (in_valid && in_ready) begin
            e.sel  = (hs_idx >= 4);
            e.addr = 7'(hs_idx % 4);
            e.data = in_data;
            e.cyc  = cyc + 2;
            exp_wr.push_back(e);
            hs_idx++;
        end
        if (we_a || we_b) begin
            if (exp_wr.size() == 0) begin
                fail("wr_unexpected");
            end else begin
                e = exp_wr.pop_front();
                check("wr_sel", {we_a, we_b}, e.sel ? 2'b01 : 2'b10);
                check("wr_addr", a_d2, e.addr);
                check("wr_data", data_pi, e.data);
                check("wr_cycle", cyc, e.cyc);
            end
        end
        if (out_valid) begin
            if (exp_out.size() == 0) begin
                fail("out_unexpected");
            end else begin
                check("out_data", out_data, exp_out.pop_front());
            end
            if (out_idx > 0) check("out_spacing", cyc, last_out + 1);
            last_out = cyc;
            out_idx++;
            out_cnt++;
        end
        if (cmd_done) begin
            done_cnt++;
            out_idx = 0;
        end
        if (start_mat_mul) run_cycles++;
        if ((int'(we_a) + int'(we_b) + int'(we_c)) > 1 ||
            (enable_writing_to_mem && enable_reading_from_mem)) excl_viol++;
    end

    task automatic send_row(input logic [31:0] w, input bit toggle);
        int  n;
        bit  acc;
        in_valid = 1'b1;
        in_data  = w;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) fail("handshake_timeout");
        in_valid = 1'b0;
        if (toggle) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        cmd_start = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
    endtask

    task automatic run_seq(input logic [3:0][31:0] a, input logic [3:0][31:0] b,
                           input logic [3:0][31:0] expc, input bit toggle, input bit expect_out);
        int d0, o0, n;
        d0 = done_cnt;
        o0 = out_cnt;
        if (expect_out) for (int i = 0; i < 4; i++) exp_out.push_back(expc[i]);
        hs_idx = 0;
        pulse_start();
        @(negedge clk);
        check("timeout_cleared", timeout_err, 1'b0);
        check("busy_after_start", busy, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send_row(a[i], toggle);
        for (int i = 0; i < 4; i++) send_row(b[i], toggle);
        n = 0;
        while (done_cnt == d0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) fail("cmd_done_timeout");
        repeat (3) @(negedge clk);
        check("one_cmd_done", done_cnt - d0, 1);
        check("busy_idle", busy, 1'b0);
        check("wr_queue_empty", exp_wr.size(), 0);
        check("out_queue_empty", exp_out.size(), 0);
        check("out_count", out_cnt - o0, expect_out ? 4 : 0);
    endtask

    logic [3:0][31:0] id_a, two_a, b1, b2, b1x2, zero4;

    initial begin
        int n;
        id_a  = {32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001};
        two_a = {32'h02000000, 32'h00020000, 32'h00000200, 32'h00000002};
        b1    = {32'h0d0e0f10, 32'h090a0b0c, 32'h05060708, 32'h01020304};
        b1x2  = {32'h1a1c1e20, 32'h12141618, 32'h0a0c0e10, 32'h02040608};
        b2    = {32'h44332211, 32'hdeadbeef, 32'h80ff7f01, 32'h11223344};
        zero4 = '0;

        // reset held with random inputs: every output must stay 0
        reset = 1'b0; rnd_phase = 1'b1; mm_en = 1'b1;
        cmd_start = 1'b0; in_valid = 1'b0; in_data = 32'd0;
        rnd_done = 1'b0; rnd_data = 32'd0;
        repeat (6) begin
            @(posedge clk); #1;
            cmd_start = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            rnd_done  = 1'($urandom_range(0, 1));
            rnd_data  = $urandom;
            @(negedge clk);
            check("reset_outputs", all_out, 82'd0);
        end
        @(posedge clk); #1;
        cmd_start = 1'b0; in_valid = 1'b0; in_data = 32'd0; rnd_phase = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_outputs", all_out, 82'd0);

        // identity A: C equals B
        run_seq(id_a, b1, b1, 1'b0, 1'b1);
        // stalled input stream, different B
        run_seq(id_a, b2, b2, 1'b1, 1'b1);

        // done never arrives: timeout path
        mm_en = 1'b0;
        run_cycles = 0;
        run_seq(id_a, b1, zero4, 1'b0, 1'b0);
        check("timeout_err_set", timeout_err, 1'b1);
        check("run_cycles", run_cycles, 255);
        mm_en = 1'b1;

        // cmd_start during RUN is ignored
        fork
            run_seq(id_a, b1, b1, 1'b0, 1'b1);
            begin
                n = 0;
                while (!start_mat_mul && n < 500) begin
                    @(negedge clk);
                    n++;
                end
                if (!start_mat_mul) fail("run_not_reached");
                @(posedge clk); #1;
                cmd_start = 1'b1;
                @(posedge clk); #1;
                cmd_start = 1'b0;
                @(negedge clk);
                check("busy_in_run", busy, 1'b1);
            end
        join

        // reset in the middle of LOAD_B aborts at once
        hs_idx = 0;
        pulse_start();
        for (int i = 0; i < 4; i++) send_row(id_a[i], 1'b0);
        for (int i = 0; i < 2; i++) send_row(b2[i], 1'b0);
        #2 reset = 1'b0;
        #1 check("reset_mid_load", all_out, 82'd0);
        @(posedge clk); #1;
        exp_wr.delete();
        exp_out.delete();
        hs_idx = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        // full sequence after the abort: A = 2*I gives C = 2*B
        run_seq(two_a, b1, b1x2, 1'b0, 1'b1);

        check("exclusivity_violations", excl_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
